// File: rtl/bus_arbiter_2m.sv
// Two-master round-robin bus arbiter with hold-limit pre-emption.
// Decides bus ownership, drives the 2:1 mux select and forwards the owner's
// address/data onto the shared 32-bit bus.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   m0_req/addr/data      master 0 request level, address, write data
//   m1_req/addr/data      master 1 request level, address, write data
//   m0_grant, m1_grant    registered ownership flags (never both high)
//   bus_sel               registered mux select (0 = m0, 1 = m1), held in idle
//   bus_addr, bus_data    shared bus payload, muxed from bus_sel
//   bus_busy              registered, high while some master is granted
module bus_arbiter_2m #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_data,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_data,
  output logic        m0_grant,
  output logic        m1_grant,
  output logic        bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_data,
  output logic        bus_busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  localparam bit             HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  // Last held cycle before the waiting master pre-empts the owner.
  localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             last_owner;
  logic             next_last;
  logic             other_req;
  logic             hold_expired;

  // Next-state, hold counter and round-robin pointer.
  always_comb begin
    next_state   = state;
    next_cnt     = '0;
    next_last    = last_owner;
    other_req    = 1'b0;
    hold_expired = HOLD_EN && (hold_cnt == HOLD_LAST);

    case (state)
      IDLE: begin
        if (m0_req && m1_req) next_state = last_owner ? GNT0 : GNT1;
        else if (m0_req)      next_state = GNT0;
        else if (m1_req)      next_state = GNT1;
      end
      GNT0: begin
        other_req = m1_req;
        if (!m0_req)                      next_state = m1_req ? GNT1 : IDLE;
        else if (m1_req && hold_expired)  next_state = GNT1;
      end
      GNT1: begin
        other_req = m0_req;
        if (!m1_req)                      next_state = m0_req ? GNT0 : IDLE;
        else if (m0_req && hold_expired)  next_state = GNT0;
      end
      default: next_state = IDLE;
    endcase

    // Counter only runs while the owner keeps the bus against a waiting master.
    if (next_state == state && other_req) begin
      next_cnt = (hold_cnt == CNT_MAX) ? hold_cnt : hold_cnt + CNT_W'(1);
    end

    if (next_state == GNT0)      next_last = 1'b0;
    else if (next_state == GNT1) next_last = 1'b1;
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      last_owner <= 1'b1;
      m0_grant   <= 1'b0;
      m1_grant   <= 1'b0;
      bus_sel    <= 1'b0;
      bus_busy   <= 1'b0;
    end else begin
      state      <= next_state;
      hold_cnt   <= next_cnt;
      last_owner <= next_last;
      m0_grant   <= (next_state == GNT0);
      m1_grant   <= (next_state == GNT1);
      bus_busy   <= (next_state != IDLE);
      if (next_state == GNT0)      bus_sel <= 1'b0;
      else if (next_state == GNT1) bus_sel <= 1'b1;
    end
  end

  // Shared-bus 2:1 mux.
  assign bus_addr = bus_sel ? m1_addr : m0_addr;
  assign bus_data = bus_sel ? m1_data : m0_data;

endmodule

// File: doc/bus_arbiter_2m.md
Name: bus_arbiter_2m

Overview:
Two-master arbiter and sequencer for the shared 32-bit bus built on the 2:1 32-bit bus multiplexer.
- Decides which master owns the bus.
- Drives the mux select and forwards the winning master's address/data onto the shared bus.
- Round-robin fairness, with a hold-limit timeout so one master cannot starve the other.

Parameters:
- MAX_HOLD, 8: max consecutive granted cycles while the other master is waiting; 0 disables the timeout.
- CNT_W, 4: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- m0_req  input  1  master 0 bus request (level, held while transferring).
- m0_addr  input  32  master 0 address.
- m0_data  input  32  master 0 write data.
- m1_req  input  1  master 1 bus request.
- m1_addr  input  32  master 1 address.
- m1_data  input  32  master 1 write data.
- m0_grant  output  1  master 0 owns the bus.
- m1_grant  output  1  master 1 owns the bus.
- bus_sel  output  1  mux select: 0 = master 0, 1 = master 1.
- bus_addr  output  32  shared bus address.
- bus_data  output  32  shared bus data.
- bus_busy  output  1  some master is granted.

Behaviour:
- Reset, synchronous active-high, sampled on the rising clk edge:
  - state=IDLE; m0_grant=0, m1_grant=0, bus_sel=0, bus_busy=0.
  - hold_cnt=0; last_owner=1, so master 0 wins the first tie.
  - Reset asserted mid-grant drops the grant on that same edge; no completion cycle.
- States: IDLE, GNT0, GNT1.
  - Grants, bus_sel and bus_busy are registered and decoded from the state.
  - m0_grant=1 only in GNT0; m1_grant=1 only in GNT1.
  - bus_sel=1 in GNT1; bus_sel holds its previous value in IDLE.
  - bus_busy = GNT0 | GNT1.
- Bus outputs:
  - bus_addr/bus_data = bus_sel ? m1_* : m0_*.
  - Combinational from the registered bus_sel, i.e. the 32-bit 2:1 mux function.
  - Consumers must ignore them when bus_busy=0.
- Latency: request asserted at edge N is granted after edge N+1; exactly 1 cycle from the IDLE state.
- IDLE transitions:
  - m0_req & m1_req -> grant the master != last_owner.
  - Only m0_req -> GNT0.
  - Only m1_req -> GNT1.
  - Neither -> stay in IDLE.
- GNT0 transitions (GNT1 is symmetric):
  - !m0_req & m1_req -> GNT1 directly, no idle bubble.
  - !m0_req & !m1_req -> IDLE.
  - m0_req & m1_req & MAX_HOLD!=0 & hold_cnt==MAX_HOLD-1 -> GNT1 (pre-emption).
  - Otherwise stay in GNT0.
- hold_cnt:
  - Cleared on any state change.
  - Increments each cycle the state is held while the other master requests.
  - Cleared while the other master does not request; saturates, never wraps.
- last_owner updates to the granted master on every entry into GNT0/GNT1.
- Never both grants high; never a grant in IDLE.
- Simultaneous release by the owner and a new request from the other master: handover happens on the same edge.

Test Plan:
- Reset, then hold reset=1 for 2 cycles with m0_req=1 -> all outputs 0, bus_busy=0.
- Release reset; m0_req=1, m0_addr=32'h12341234, m0_data=32'hffffffff -> next edge m0_grant=1, bus_sel=0, bus_addr=32'h12341234, bus_data=32'hffffffff.
- Both requests from IDLE after reset -> master 0 granted. Release both and re-request both -> master 1 granted, bus_addr=m1_addr=32'h99995959.
- Master 0 in GNT0; at edge N drop m0_req and raise m1_req (m1_data=32'h11111111) -> after edge N+1 m1_grant=1 with no IDLE cycle; bus_data=32'h11111111.
- MAX_HOLD=8; m0 granted, m1_req raised and both held -> m0_grant high for exactly 8 cycles, then m1_grant=1. Repeat with MAX_HOLD=0 -> m0 holds indefinitely.
- Assert reset while in GNT1 -> on that edge m1_grant=0, bus_busy=0, bus_sel=0. With both requests still present after release -> master 0 granted.
